// File: rtl/rf_op_sequencer.sv
// Register-file operation sequencer: accepts one ALU command, reads two operands,
// executes, writes the result back and pulses done (IDLE->READ->EXEC->WRITE->DONE).
module rf_op_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  opcode,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic [3:0]  dst,
    output logic        rd_en,
    output logic [3:0]  rAddr1,
    output logic [3:0]  rAddr2,
    input  logic [31:0] rData1,
    input  logic [31:0] rData2,
    output logic        we,
    output logic [3:0]  wAddr,
    output logic [31:0] wData,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_t;

    state_t      state_q, state_d;
    opcode_t     op_q, op_d;
    logic [3:0]  src1_q, src1_d;
    logic [3:0]  src2_q, src2_d;
    logic [3:0]  dst_q, dst_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;

    logic [32:0] sum_w;
    logic [31:0] alu_res;
    logic        alu_carry;

    // ALU on the registered operands
    always_comb begin
        sum_w     = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = '0;
        alu_carry = 1'b0;
        unique case (op_q)
            OP_ADD: {alu_carry, alu_res} = sum_w;
            OP_SUB: begin
                alu_res   = a_q - b_q;
                alu_carry = (a_q < b_q);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: alu_res = a_q << b_q[4:0];
            OP_SHR: alu_res = a_q >> b_q[4:0];
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dst_d    = dst_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d    = opcode_t'(opcode);
                    src1_d  = src1;
                    src2_d  = src2;
                    dst_d   = dst;
                    state_d = READ;
                end
            end
            READ: begin
                a_d     = rData1;
                b_d     = rData2;
                state_d = EXEC;
            end
            EXEC: begin
                // NOP bypasses WRITE and leaves the flags/result untouched
                if (op_q == OP_NOP) begin
                    state_d = DONE;
                end else begin
                    result_d = alu_res;
                    carry_d  = alu_carry;
                    zero_d   = (alu_res == '0);
                    state_d  = WRITE;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_NOP;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dst_q    <= dst_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
        end
    end

    // Strobes are gated by reset_n so a reset landing in READ/WRITE issues no access
    always_comb begin
        op_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        rd_en    = (state_q == READ) && reset_n;
        rAddr1   = (state_q == READ) ? src1_q : '0;
        rAddr2   = (state_q == READ) ? src2_q : '0;
        we       = (state_q == WRITE) && reset_n;
        wAddr    = (state_q == WRITE) ? dst_q : '0;
        wData    = result_q;
        result   = result_q;
        zero     = zero_q;
        carry    = carry_q;
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Scoreboard bench for rf_op_sequencer: a register-file model feeds the DUT, commands
// push expected responses, and a negedge monitor checks reads, writes and done pulses.
module tb_rf_op_sequencer;

    logic        clk;
    logic        reset_n;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  opcode;
    logic [3:0]  src1, src2, dst;
    logic        rd_en;
    logic [3:0]  rAddr1, rAddr2;
    logic [31:0] rData1, rData2;
    logic        we;
    logic [3:0]  wAddr;
    logic [31:0] wData;
    logic [31:0] result;
    logic        zero, carry, busy, done;

    rf_op_sequencer dut (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .src1(src1), .src2(src2), .dst(dst),
        .rd_en(rd_en), .rAddr1(rAddr1), .rAddr2(rAddr2),
        .rData1(rData1), .rData2(rData2),
        .we(we), .wAddr(wAddr), .wData(wData),
        .result(result), .zero(zero), .carry(carry), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf [16];
    assign rData1 = rf[rAddr1];
    assign rData2 = rf[rAddr2];
    always @(posedge clk) if (we) rf[wAddr] <= wData;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  s1, s2, d;
        logic [31:0] res;
        logic        c, z;
    } vec_t;

    typedef struct {
        logic [3:0]  s1, s2, d;
        logic [31:0] res;
        logic        c, z;
        logic        has_write;
        logic        wr_seen;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int n_acc = 0;
    int n_push = 0;
    int prev_cyc = 0;
    int prev_lat = 0;
    bit have_prev = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head
    always @(negedge clk) begin
        if (reset_n) begin
            if (op_valid && op_ready) n_acc++;
            chk("ready_vs_busy", {31'd0, op_ready}, {31'd0, ~busy});
            chk("wdata_is_result", wData, result);
            if (rd_en) begin
                if (sb.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else begin
                    chk("rAddr1", {28'd0, rAddr1}, {28'd0, sb[0].s1});
                    chk("rAddr2", {28'd0, rAddr2}, {28'd0, sb[0].s2});
                end
            end else begin
                chk("rAddr_idle", {24'd0, rAddr1, rAddr2}, 32'd0);
            end
            if (we) begin
                if (sb.size() == 0 || !sb[0].has_write || sb[0].wr_seen)
                    chk("we_unexpected", 32'd1, 32'd0);
                else begin
                    chk("wAddr", {28'd0, wAddr}, {28'd0, sb[0].d});
                    chk("wData", wData, sb[0].res);
                    sb[0].wr_seen = 1'b1;
                end
            end else begin
                chk("wAddr_idle", {28'd0, wAddr}, 32'd0);
            end
            if (done) begin
                if (sb.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else begin
                    chk("result", result, sb[0].res);
                    chk("carry", {31'd0, carry}, {31'd0, sb[0].c});
                    chk("zero", {31'd0, zero}, {31'd0, sb[0].z});
                    chk("latency", cyc, sb[0].done_cyc);
                    chk("write_count", {31'd0, sb[0].wr_seen}, {31'd0, sb[0].has_write});
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Leaves op_valid high after the accept so it is also held during busy
    task automatic issue(input vec_t v);
        int waited = 0;
        exp_t e;
        @(negedge clk);
        opcode = v.op; src1 = v.s1; src2 = v.s2; dst = v.d;
        op_valid = 1'b1;
        while (!op_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        e.s1 = v.s1; e.s2 = v.s2; e.d = v.d;
        e.res = v.res; e.c = v.c; e.z = v.z;
        e.has_write = (v.op != 3'b000);
        e.wr_seen = 1'b0;
        e.done_cyc = cyc + ((v.op == 3'b000) ? 3 : 4);
        sb.push_back(e);
        n_push++;
        if (have_prev) chk("accept_gap", cyc - prev_cyc, prev_lat + 1);
        prev_cyc = cyc;
        prev_lat = (v.op == 3'b000) ? 3 : 4;
        have_prev = 1'b1;
    endtask

    vec_t vecs[12];

    initial begin
        int k;
        vec_t rv;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        vec_t rv;
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        rf[1]  = 32'h0000_0005; rf[2]  = 32'h0000_0003;
        rf[4]  = 32'h8000_0001; rf[5]  = 32'h0000_0021;
        rf[8]  = 32'hF0F0_1234; rf[9]  = 32'h0FF0_00FF;
        rf[10] = 32'hFFFF_FFE4; rf[11] = 32'hFFFF_FFFF; rf[12] = 32'h0000_0001;

        vecs[0]  = '{3'b001, 4'd1,  4'd2,  4'd3,  32'h0000_0008, 1'b0, 1'b0};
        vecs[1]  = '{3'b000, 4'd0,  4'd0,  4'd0,  32'h0000_0008, 1'b0, 1'b0};
        vecs[2]  = '{3'b000, 4'd0,  4'd0,  4'd0,  32'h0000_0008, 1'b0, 1'b0};
        vecs[3]  = '{3'b001, 4'd11, 4'd12, 4'd6,  32'h0000_0000, 1'b1, 1'b1};
        vecs[4]  = '{3'b010, 4'd12, 4'd11, 4'd7,  32'h0000_0002, 1'b1, 1'b0};
        vecs[5]  = '{3'b010, 4'd1,  4'd1,  4'd13, 32'h0000_0000, 1'b0, 1'b1};
        vecs[6]  = '{3'b000, 4'd0,  4'd0,  4'd0,  32'h0000_0000, 1'b0, 1'b1};
        vecs[7]  = '{3'b111, 4'd4,  4'd5,  4'd4,  32'h4000_0000, 1'b0, 1'b0};
        vecs[8]  = '{3'b011, 4'd8,  4'd9,  4'd14, 32'h00F0_0034, 1'b0, 1'b0};
        vecs[9]  = '{3'b100, 4'd8,  4'd9,  4'd15, 32'hFFF0_12FF, 1'b0, 1'b0};
        vecs[10] = '{3'b101, 4'd8,  4'd9,  4'd0,  32'hFF00_12CB, 1'b0, 1'b0};
        vecs[11] = '{3'b110, 4'd8,  4'd10, 4'd2,  32'h0F01_2340, 1'b0, 1'b0};

        reset_n = 1'b0; op_valid = 1'b0; opcode = '0; src1 = '0; src2 = '0; dst = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'd0, zero, carry}, 32'd0);
        chk("rst_strobes", {30'd0, we, rd_en}, 32'd0);

        foreach (vecs[i]) issue(vecs[i]);

        // Reset landing in the WRITE cycle of an in-flight ADD to R5
        rv = '{3'b001, 4'd1, 4'd2, 4'd5, 32'h0, 1'b0, 1'b0};
        issue(rv);
        @(negedge clk);
        op_valid = 1'b0;
        waited = 0;
        while (cyc != prev_cyc + 3 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("reach_write", cyc, prev_cyc + 3);
        chk("we_before_rst", {31'd0, we}, 32'd1);
        reset_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("we_gated_rst", {31'd0, we}, 32'd0);
        chk("rd_gated_rst", {31'd0, rd_en}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, op_ready}, 32'd1);
        chk("post_rst_result", result, 32'd0);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        repeat (6) @(negedge clk);

        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("sb_drained", sb.size(), 32'd0);
        chk("accepts", n_acc, n_push);
        chk("rf3",  rf[3],  32'h0000_0008);
        chk("rf4",  rf[4],  32'h4000_0000);
        chk("rf5",  rf[5],  32'h0000_0021);
        chk("rf6",  rf[6],  32'h0000_0000);
        chk("rf7",  rf[7],  32'h0000_0002);
        chk("rf14", rf[14], 32'h00F0_0034);
        chk("rf15", rf[15], 32'hFFF0_12FF);
        chk("rf0",  rf[0],  32'hFF00_12CB);
        chk("rf2",  rf[2],  32'h0F01_2340);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
